// File: rtl/transfer_status_tx_pkg.sv
// Shared constants, FSM encoding and packet helpers for the Ethernet
// status return path (package eth_status_pkg).
package eth_status_pkg;

  localparam logic [7:0]  STATUS_MAGIC       = 8'hA5;
  localparam logic [7:0]  TYPE_ALL_ACK       = 8'h10;
  localparam logic [3:0]  TYPE_SINGLE_ACK_HI = 4'h8;
  localparam logic [7:0]  TYPE_FRAME_DONE    = 8'hD0;

  // Payload length in bytes: two words, or three with the checksum word
  localparam logic [15:0] BYTE_NUM_BASE      = 16'd8;
  localparam logic [15:0] BYTE_NUM_CSUM      = 16'd12;

  // Bit positions of the pending-event vector
  localparam int EVT_ALL_BIT    = 0;
  localparam int EVT_SINGLE_BIT = 1;
  localparam int EVT_DONE_BIT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XMIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_ALL    = 2'd1,
    EV_SINGLE = 2'd2,
    EV_DONE   = 2'd3
  } evt_t;

  // Type byte of word0 for a given event
  function automatic logic [7:0] pkt_type(input evt_t ev, input logic [3:0] sel);
    case (ev)
      EV_ALL:    return TYPE_ALL_ACK;
      EV_SINGLE: return {TYPE_SINGLE_ACK_HI, sel};
      default:   return TYPE_FRAME_DONE;
    endcase
  endfunction

endpackage

// File: rtl/transfer_status_tx_if.sv
// Request/data bus shared with the UDP transmit engine.
// master = status transmitter, slave = UDP engine.
interface transfer_status_tx_if;
  logic        udp_tx_start_en;
  logic [15:0] udp_tx_byte_num;
  logic        udp_tx_req;
  logic [31:0] udp_tx_data;
  logic        udp_tx_done;

  modport master (
    output udp_tx_start_en,
    output udp_tx_byte_num,
    output udp_tx_data,
    input  udp_tx_req,
    input  udp_tx_done
  );

  modport slave (
    input  udp_tx_start_en,
    input  udp_tx_byte_num,
    input  udp_tx_data,
    output udp_tx_req,
    output udp_tx_done
  );
endinterface

// File: rtl/transfer_status_tx_event_latch.sv
// status_event_latch: captures the three status events into pending bits,
// keeps the newest camera select, and reports the highest-priority event
// (all > single > done).
module status_event_latch
  import eth_status_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_all_flag,
  input  logic       i_single_pulse,
  input  logic [3:0] i_sel,
  input  logic       i_done_pulse,
  input  logic [2:0] i_clr,
  output logic [2:0] o_pend,
  output logic [3:0] o_sel_q,
  output evt_t       o_top_evt
);

  logic       r_all_d;
  logic [2:0] r_pend;
  logic [3:0] r_sel_q;
  logic [2:0] w_set;

  // The all-frame flag may stay high for several cycles; only its rising edge counts
  assign w_set[EVT_ALL_BIT]    = i_all_flag & ~r_all_d;
  assign w_set[EVT_SINGLE_BIT] = i_single_pulse;
  assign w_set[EVT_DONE_BIT]   = i_done_pulse;

  // Pending bits: a new event beats a coincident clear so nothing is lost;
  // repeats of an already pending event simply merge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_all_d <= 1'b0;
      r_pend  <= 3'b000;
      r_sel_q <= 4'h0;
    end else begin
      r_all_d <= i_all_flag;
      r_pend  <= w_set | (r_pend & ~i_clr);
      if (i_single_pulse) r_sel_q <= i_sel;
    end
  end

  // Fixed priority pick among the pending events
  always_comb begin
    o_top_evt = EV_NONE;
    if (r_pend[EVT_ALL_BIT])         o_top_evt = EV_ALL;
    else if (r_pend[EVT_SINGLE_BIT]) o_top_evt = EV_SINGLE;
    else if (r_pend[EVT_DONE_BIT])   o_top_evt = EV_DONE;
  end

  assign o_pend  = r_pend;
  assign o_sel_q = r_sel_q;

endmodule

// File: rtl/transfer_status_tx.sv
// transfer_status_tx: sends a fixed-format status packet to the UDP engine
// for all-frame commands, single-camera commands and completed frames.
// Optional checksum word enabled by defining STATUS_TX_CHECKSUM_EN.
module transfer_status_tx
  import eth_status_pkg::*;
#(
  parameter int unsigned TX_TIMEOUT = 2_000_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        transfer_all_frame_flag,
  input  logic                        transfer_signle_frame_flag,
  input  logic [3:0]                  transfer_cmos_sel,
  input  logic                        frame_transfer_done,
  transfer_status_tx_if.master        udp_if,
  output logic                        status_busy,
  output logic                        tx_timeout
);

`ifdef STATUS_TX_CHECKSUM_EN
  localparam logic [15:0] BYTE_NUM = BYTE_NUM_CSUM;
`else
  localparam logic [15:0] BYTE_NUM = BYTE_NUM_BASE;
`endif
  localparam logic [31:0] TMO_LAST = 32'(TX_TIMEOUT - 1);

  state_t      r_state;
  logic        r_start_en;
  logic        r_busy;
  logic        r_timeout;
  logic [31:0] r_data;
  logic [1:0]  r_idx;
  logic [7:0]  r_seq;
  logic [31:0] r_frame_cnt;
  logic [31:0] r_tmo_cnt;
  logic [31:0] r_word0;
  logic [31:0] r_word1;
`ifdef STATUS_TX_CHECKSUM_EN
  logic [31:0] r_word2;
  logic [15:0] w_sum16;
`endif

  logic [2:0]  w_pend;
  logic [2:0]  w_clr;
  logic [3:0]  w_sel_q;
  evt_t        w_evt;
  logic [3:0]  w_pkt_sel;
  logic [31:0] w_word0;
  logic [31:0] w_word;

  status_event_latch u_latch (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_all_flag     (transfer_all_frame_flag),
    .i_single_pulse (transfer_signle_frame_flag),
    .i_sel          (transfer_cmos_sel),
    .i_done_pulse   (frame_transfer_done),
    .i_clr          (w_clr),
    .o_pend         (w_pend),
    .o_sel_q        (w_sel_q),
    .o_top_evt      (w_evt)
  );

  // Clear exactly the event being sent, only in the START cycle
  always_comb begin
    w_clr = 3'b000;
    if (r_state == ST_START) begin
      case (w_evt)
        EV_ALL:    w_clr[EVT_ALL_BIT]    = 1'b1;
        EV_SINGLE: w_clr[EVT_SINGLE_BIT] = 1'b1;
        EV_DONE:   w_clr[EVT_DONE_BIT]   = 1'b1;
        default:   w_clr = 3'b000;
      endcase
    end
  end

  assign w_pkt_sel = (w_evt == EV_SINGLE) ? w_sel_q : 4'h0;
  assign w_word0   = {STATUS_MAGIC, pkt_type(w_evt, w_sel_q), 4'h0, w_pkt_sel, r_seq};
`ifdef STATUS_TX_CHECKSUM_EN
  assign w_sum16   = w_word0[31:16] + w_word0[15:0] + r_frame_cnt[31:16] + r_frame_cnt[15:0];
`endif

  // Word mux; anything past the last word reads as zero
  always_comb begin
    w_word = 32'h0;
    case (r_idx)
      2'd0:    w_word = r_word0;
      2'd1:    w_word = r_word1;
`ifdef STATUS_TX_CHECKSUM_EN
      2'd2:    w_word = r_word2;
`endif
      default: w_word = 32'h0;
    endcase
  end

  // Frame counter counts every completed frame, merged or not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame_cnt <= 32'h0;
    else if (frame_transfer_done) r_frame_cnt <= r_frame_cnt + 32'd1;
  end

  // Packet FSM with registered start/busy/timeout/data outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_start_en <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_data     <= 32'h0;
      r_idx      <= 2'd0;
      r_seq      <= 8'h00;
      r_tmo_cnt  <= 32'h0;
      r_word0    <= 32'h0;
      r_word1    <= 32'h0;
`ifdef STATUS_TX_CHECKSUM_EN
      r_word2    <= 32'h0;
`endif
    end else begin
      r_start_en <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tmo_cnt <= 32'h0;
          if (|w_pend) begin
            r_state    <= ST_START;
            r_start_en <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_START: begin
          r_word0   <= w_word0;
          r_word1   <= r_frame_cnt;
`ifdef STATUS_TX_CHECKSUM_EN
          r_word2   <= {16'h0000, w_sum16};
`endif
          r_seq     <= r_seq + 8'd1;
          r_idx     <= 2'd0;
          r_tmo_cnt <= r_tmo_cnt + 32'd1;
          r_state   <= ST_XMIT;
        end
        ST_XMIT: begin
          if (udp_if.udp_tx_req) begin
            r_data <= w_word;
            if (r_idx != 2'd3) r_idx <= r_idx + 2'd1;
          end
          if (udp_if.udp_tx_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign udp_if.udp_tx_start_en = r_start_en;
  assign udp_if.udp_tx_byte_num = BYTE_NUM;
  assign udp_if.udp_tx_data     = r_data;
  assign status_busy            = r_busy;
  assign tx_timeout             = r_timeout;

endmodule

// File: tb/tb_transfer_status_tx.sv
// Directed testbench for transfer_status_tx; one task per scenario.
module tb_transfer_status_tx;

  localparam int unsigned TMO = 40;
`ifdef STATUS_TX_CHECKSUM_EN
  localparam logic [15:0] EXP_BN = 16'd12;
`else
  localparam logic [15:0] EXP_BN = 16'd8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       transfer_all_frame_flag = 1'b0;
  logic       transfer_signle_frame_flag = 1'b0;
  logic [3:0] transfer_cmos_sel = 4'h0;
  logic       frame_transfer_done = 1'b0;
  logic       status_busy;
  logic       tx_timeout;

  int checks = 0;
  int failures = 0;

  transfer_status_tx_if u_if ();

  transfer_status_tx #(.TX_TIMEOUT(TMO)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .transfer_all_frame_flag    (transfer_all_frame_flag),
    .transfer_signle_frame_flag (transfer_signle_frame_flag),
    .transfer_cmos_sel          (transfer_cmos_sel),
    .frame_transfer_done        (frame_transfer_done),
    .udp_if                     (u_if),
    .status_busy                (status_busy),
    .tx_timeout                 (tx_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    transfer_all_frame_flag = 1'b0;
    transfer_signle_frame_flag = 1'b0;
    transfer_cmos_sel = 4'h0;
    frame_transfer_done = 1'b0;
    u_if.udp_tx_req = 1'b0;
    u_if.udp_tx_done = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_single(input logic [3:0] sel);
    transfer_signle_frame_flag = 1'b1;
    transfer_cmos_sel = sel;
    tick();
    transfer_signle_frame_flag = 1'b0;
  endtask

  task automatic pulse_done();
    frame_transfer_done = 1'b1;
    tick();
    frame_transfer_done = 1'b0;
  endtask

  task automatic pulse_all();
    transfer_all_frame_flag = 1'b1;
    tick();
    transfer_all_frame_flag = 1'b0;
  endtask

  // Waits (bounded) until udp_tx_start_en is seen; returns cycles waited
  task automatic wait_start(output logic ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      cyc = i + 1;
      if (u_if.udp_tx_start_en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // From START (or XMIT): issue nreq requests, then done (optionally with the last req)
  task automatic xmit(input int nreq, input logic done_with_last,
                      output logic [31:0] w0, output logic [31:0] w1, output logic [31:0] w2,
                      output logic se_x, output logic busy_x);
    w0 = 32'h0; w1 = 32'h0; w2 = 32'h0;
    tick();
    se_x = u_if.udp_tx_start_en;
    for (int i = 0; i < nreq; i++) begin
      u_if.udp_tx_req = 1'b1;
      if (done_with_last && i == nreq - 1) u_if.udp_tx_done = 1'b1;
      tick();
      u_if.udp_tx_req = 1'b0;
      u_if.udp_tx_done = 1'b0;
      if (i == 0) w0 = u_if.udp_tx_data;
      else if (i == 1) w1 = u_if.udp_tx_data;
      else w2 = u_if.udp_tx_data;
    end
    if (!done_with_last) begin
      u_if.udp_tx_done = 1'b1;
      tick();
      u_if.udp_tx_done = 1'b0;
    end
    busy_x = status_busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (u_if.udp_tx_start_en !== 1'b0) begin failures++; $display("FAIL reset_start_en got=%b exp=0", u_if.udp_tx_start_en); end
    checks++; if (u_if.udp_tx_byte_num !== EXP_BN) begin failures++; $display("FAIL reset_byte_num got=%0d exp=%0d", u_if.udp_tx_byte_num, EXP_BN); end
    checks++; if (u_if.udp_tx_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", u_if.udp_tx_data); end
    checks++; if (status_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", status_busy); end
    checks++; if (tx_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", tx_timeout); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic ok, se, bz;
    int cyc;
    logic [31:0] w0, w1, w2;
    do_reset();
    pulse_single(4'h3);
    checks++; if (u_if.udp_tx_start_en !== 1'b0) begin failures++; $display("FAIL single_early_start got=%b exp=0", u_if.udp_tx_start_en); end
    wait_start(ok, cyc);
    checks++; if (!ok || cyc != 1) begin failures++; $display("FAIL single_latency ok=%b cyc=%0d exp=1", ok, cyc); end
    checks++; if (status_busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", status_busy); end
    checks++; if (u_if.udp_tx_byte_num !== EXP_BN) begin failures++; $display("FAIL single_byte_num got=%0d exp=%0d", u_if.udp_tx_byte_num, EXP_BN); end
    xmit(3, 1'b0, w0, w1, w2, se, bz);
    checks++; if (se !== 1'b0) begin failures++; $display("FAIL single_start_pulse_width got=%b exp=0", se); end
    checks++; if (w0 !== 32'hA583_0300) begin failures++; $display("FAIL single_word0 got=%h exp=a5830300", w0); end
    checks++; if (w1 !== 32'h0000_0000) begin failures++; $display("FAIL single_word1 got=%h exp=00000000", w1); end
`ifdef STATUS_TX_CHECKSUM_EN
    // A583 + 0300 + 0000 + 0000
    checks++; if (w2 !== 32'h0000_A883) begin failures++; $display("FAIL single_word2 got=%h exp=0000a883", w2); end
`else
    checks++; if (w2 !== 32'h0000_0000) begin failures++; $display("FAIL single_word_past_end got=%h exp=00000000", w2); end
`endif
    checks++; if (bz !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", bz); end
    $display("test_single word0=%h word1=%h word2=%h", w0, w1, w2);
  endtask

  task automatic test_all_seq();
    logic ok, se, bz, seen;
    int cyc, starts;
    logic [31:0] w0, w1, w2;
    do_reset();
    seen = 1'b0;
    transfer_all_frame_flag = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (u_if.udp_tx_start_en) seen = 1'b1;
    end
    transfer_all_frame_flag = 1'b0;
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL all_start_seen got=%b exp=1", seen); end
    xmit(2, 1'b0, w0, w1, w2, se, bz);
    checks++; if (w0 !== 32'hA510_0000) begin failures++; $display("FAIL all_word0 got=%h exp=a5100000", w0); end
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (u_if.udp_tx_start_en) starts++;
    end
    checks++; if (starts != 0) begin failures++; $display("FAIL all_extra_packets got=%0d exp=0", starts); end
    pulse_all();
    wait_start(ok, cyc);
    xmit(2, 1'b0, w0, w1, w2, se, bz);
    checks++; if (!ok || w0 !== 32'hA510_0001) begin failures++; $display("FAIL all_second_word0 ok=%b got=%h exp=a5100001", ok, w0); end
    $display("test_all_seq second word0=%h", w0);
  endtask

  task automatic test_priority();
    logic ok, se, bz;
    int cyc;
    logic [31:0] w0, w1, w2;
    do_reset();
    transfer_all_frame_flag = 1'b1;
    transfer_signle_frame_flag = 1'b1;
    transfer_cmos_sel = 4'h5;
    frame_transfer_done = 1'b1;
    tick();
    transfer_all_frame_flag = 1'b0;
    transfer_signle_frame_flag = 1'b0;
    frame_transfer_done = 1'b0;
    wait_start(ok, cyc);
    xmit(2, 1'b0, w0, w1, w2, se, bz);
    checks++; if (!ok || w0 !== 32'hA510_0000) begin failures++; $display("FAIL prio_pkt1_word0 ok=%b got=%h exp=a5100000", ok, w0); end
    wait_start(ok, cyc);
    xmit(2, 1'b0, w0, w1, w2, se, bz);
    checks++; if (!ok || w0 !== 32'hA585_0501) begin failures++; $display("FAIL prio_pkt2_word0 ok=%b got=%h exp=a5850501", ok, w0); end
    wait_start(ok, cyc);
    xmit(2, 1'b0, w0, w1, w2, se, bz);
    checks++; if (!ok || w0 !== 32'hA5D0_0002) begin failures++; $display("FAIL prio_pkt3_word0 ok=%b got=%h exp=a5d00002", ok, w0); end
    checks++; if (w1 !== 32'd1) begin failures++; $display("FAIL prio_pkt3_word1 got=%h exp=00000001", w1); end
    $display("test_priority last word0=%h word1=%h", w0, w1);
  endtask

  task automatic test_timeout();
    logic ok, se, bz, seen, busy_at;
    int cyc, k;
    logic [31:0] w0, w1, w2;
    do_reset();
    pulse_single(4'h9);
    wait_start(ok, cyc);
    checks++; if (!ok) begin failures++; $display("FAIL tmo_start got=0 exp=1"); end
    k = 0; seen = 1'b0; busy_at = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 5) frame_transfer_done = 1'b1;
      if (i == 6) frame_transfer_done = 1'b0;
      tick();
      k++;
      if (tx_timeout) begin
        seen = 1'b1;
        busy_at = status_busy;
        break;
      end
    end
    checks++; if (!seen || k != int'(TMO)) begin failures++; $display("FAIL tmo_cycle seen=%b got=%0d exp=%0d", seen, k, TMO); end
    checks++; if (busy_at !== 1'b0) begin failures++; $display("FAIL tmo_busy got=%b exp=0", busy_at); end
    tick();
    checks++; if (tx_timeout !== 1'b0) begin failures++; $display("FAIL tmo_pulse_width got=%b exp=0", tx_timeout); end
    checks++; if (u_if.udp_tx_start_en !== 1'b1) begin failures++; $display("FAIL tmo_next_start got=%b exp=1", u_if.udp_tx_start_en); end
    xmit(2, 1'b0, w0, w1, w2, se, bz);
    checks++; if (w0 !== 32'hA5D0_0001 || w1 !== 32'd1) begin failures++; $display("FAIL tmo_next_pkt got=%h/%h exp=a5d00001/00000001", w0, w1); end
    $display("test_timeout timeout after %0d cycles, next word0=%h", k, w0);
  endtask

  task automatic test_merge();
    logic ok, se, bz;
    int cyc, starts;
    logic [31:0] w0, w1, w2;
    do_reset();
    pulse_single(4'h3);
    wait_start(ok, cyc);
    pulse_done();
    pulse_done();
    pulse_single(4'h1);
    pulse_single(4'h7);
    xmit(2, 1'b0, w0, w1, w2, se, bz);
    checks++; if (!ok || w0 !== 32'hA583_0300) begin failures++; $display("FAIL merge_pkt1_word0 ok=%b got=%h exp=a5830300", ok, w0); end
    wait_start(ok, cyc);
    xmit(2, 1'b0, w0, w1, w2, se, bz);
    checks++; if (!ok || w0 !== 32'hA587_0701) begin failures++; $display("FAIL merge_single_word0 ok=%b got=%h exp=a5870701", ok, w0); end
    wait_start(ok, cyc);
    xmit(2, 1'b0, w0, w1, w2, se, bz);
    checks++; if (!ok || w0 !== 32'hA5D0_0002) begin failures++; $display("FAIL merge_done_word0 ok=%b got=%h exp=a5d00002", ok, w0); end
    checks++; if (w1 !== 32'd2) begin failures++; $display("FAIL merge_done_word1 got=%h exp=00000002", w1); end
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (u_if.udp_tx_start_en) starts++;
    end
    checks++; if (starts != 0) begin failures++; $display("FAIL merge_extra_packets got=%0d exp=0", starts); end
    $display("test_merge done word0=%h word1=%h", w0, w1);
  endtask

  task automatic test_seq_wrap();
    logic ok, se, bz;
    int cyc, missing;
    logic [31:0] w0, w1, w2;
    do_reset();
    missing = 0;
    for (int p = 0; p <= 256; p++) begin
      pulse_done();
      wait_start(ok, cyc);
      if (!ok) missing++;
      xmit(2, 1'b0, w0, w1, w2, se, bz);
      if (p == 255) begin
        checks++; if (w0 !== 32'hA5D0_00FF || w1 !== 32'd256) begin failures++; $display("FAIL wrap_pkt255 got=%h/%h exp=a5d000ff/00000100", w0, w1); end
      end
    end
    checks++; if (missing != 0) begin failures++; $display("FAIL wrap_missing_starts got=%0d exp=0", missing); end
    checks++; if (w0 !== 32'hA5D0_0000 || w1 !== 32'd257) begin failures++; $display("FAIL wrap_pkt256 got=%h/%h exp=a5d00000/00000101", w0, w1); end
    $display("test_seq_wrap pkt256 word0=%h word1=%h", w0, w1);
  endtask

  task automatic test_req_done_same();
    logic ok, se, bz;
    int cyc;
    logic [31:0] w0, w1, w2;
    do_reset();
    pulse_single(4'h2);
    wait_start(ok, cyc);
    xmit(1, 1'b1, w0, w1, w2, se, bz);
    checks++; if (!ok || w0 !== 32'hA582_0200) begin failures++; $display("FAIL reqdone_word0 ok=%b got=%h exp=a5820200", ok, w0); end
    checks++; if (bz !== 1'b0) begin failures++; $display("FAIL reqdone_exit busy=%b exp=0", bz); end
    u_if.udp_tx_req = 1'b1;
    u_if.udp_tx_done = 1'b1;
    tick();
    u_if.udp_tx_req = 1'b0;
    u_if.udp_tx_done = 1'b0;
    tick();
    checks++; if (u_if.udp_tx_data !== 32'hA582_0200) begin failures++; $display("FAIL idle_req_ignored got=%h exp=a5820200", u_if.udp_tx_data); end
    $display("test_req_done_same word0=%h", w0);
  endtask

  task automatic test_reset_mid();
    logic ok, se, bz;
    int cyc, starts;
    logic [31:0] w0, w1, w2;
    do_reset();
    pulse_done();
    wait_start(ok, cyc);
    tick();
    pulse_single(4'h4);
    rst_n = 1'b0;
    #2;
    checks++; if (status_busy !== 1'b0 || u_if.udp_tx_data !== 32'h0) begin failures++; $display("FAIL midreset_state busy=%b data=%h exp=0/0", status_busy, u_if.udp_tx_data); end
    tick();
    rst_n = 1'b1;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (u_if.udp_tx_start_en) starts++;
    end
    checks++; if (starts != 0) begin failures++; $display("FAIL midreset_pending_kept got=%0d exp=0", starts); end
    pulse_done();
    wait_start(ok, cyc);
    xmit(2, 1'b0, w0, w1, w2, se, bz);
    checks++; if (!ok || w0 !== 32'hA5D0_0000 || w1 !== 32'd1) begin failures++; $display("FAIL midreset_next ok=%b got=%h/%h exp=a5d00000/00000001", ok, w0, w1); end
    $display("test_reset_mid next word0=%h word1=%h", w0, w1);
  endtask

  initial begin
    u_if.udp_tx_req = 1'b0;
    u_if.udp_tx_done = 1'b0;
    test_reset();
    test_single();
    test_all_seq();
    test_priority();
    test_timeout();
    test_merge();
    test_seq_wrap();
    test_req_done_same();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
